dispensador_cambio: RTL

- Change-return FSM for the coffee-machine datapath; the outbound counterpart of the coin-input summer.
- Takes inserted credit and drink price, computes the change, then ejects it one coin at a time to the coin ejector over a valid/ready handshake.
- Coin codes match the coin-input encoding: 01 = 100, 10 = 500.
- Greedy dispense: all 500 coins first, then 100 coins.

---
 rtl/dispensador_cambio.sv | 133 +++++++++++++
 1 files changed

// File: rtl/dispensador_cambio.sv
// Change-return FSM: latches credit and price, then ejects the change one coin at a
// time over a valid/ready handshake, greedy (500s first, then 100s).
module dispensador_cambio #(
   parameter int CREDIT_W = 12,
   parameter int CNT_W    = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [CREDIT_W-1:0] credito,
   input  logic [CREDIT_W-1:0] precio,
   input  logic                coin_ready,
   output logic                coin_valid,
   output logic [1:0]          coin_out,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [CNT_W-1:0]    n500,
   output logic [CNT_W-1:0]    n100,
   output logic [CREDIT_W-1:0] residuo
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      EJECT = 3'd2,
      DONE  = 3'd3,
      ERROR = 3'd4
   } state_t;

   localparam logic [1:0]          COIN_NONE = 2'b00;
   localparam logic [1:0]          COIN_100  = 2'b01;
   localparam logic [1:0]          COIN_500  = 2'b10;
   localparam logic [CREDIT_W-1:0] VAL_100   = CREDIT_W'(100);
   localparam logic [CREDIT_W-1:0] VAL_500   = CREDIT_W'(500);
   localparam logic [CNT_W-1:0]    CNT_MAX   = '1;

   state_t              state, state_nxt;
   logic [CREDIT_W-1:0] rem, rem_nxt;
   logic [CREDIT_W-1:0] residuo_q, residuo_nxt;
   logic [CNT_W-1:0]    n500_q, n500_nxt;
   logic [CNT_W-1:0]    n100_q, n100_nxt;
   logic [1:0]          coin, coin_nxt;
   logic                uf, uf_nxt;

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // pre-edge values of the others; blocking here would create order-dependent races.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rem       <= '0;
         residuo_q <= '0;
         n500_q    <= '0;
         n100_q    <= '0;
         coin      <= COIN_NONE;
         uf        <= 1'b0;
      end else begin
         state     <= state_nxt;
         rem       <= rem_nxt;
         residuo_q <= residuo_nxt;
         n500_q    <= n500_nxt;
         n100_q    <= n100_nxt;
         coin      <= coin_nxt;
         uf        <= uf_nxt;
      end
   end

   // NOTE: every signal gets a hold-value default before the case so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt   = state;
      rem_nxt     = rem;
      residuo_nxt = residuo_q;
      n500_nxt    = n500_q;
      n100_nxt    = n100_q;
      coin_nxt    = coin;
      uf_nxt      = uf;

      unique case (state)
         IDLE: begin
            if (start) begin
               rem_nxt     = credito - precio;
               uf_nxt      = (credito < precio);
               n500_nxt    = '0;
               n100_nxt    = '0;
               residuo_nxt = '0;
               state_nxt   = CHECK;
            end
         end
         CHECK: begin
            if (uf) begin
               state_nxt = ERROR;
            end else if (rem >= VAL_500) begin
               coin_nxt  = COIN_500;
               state_nxt = EJECT;
            end else if (rem >= VAL_100) begin
               coin_nxt  = COIN_100;
               state_nxt = EJECT;
            end else begin
               residuo_nxt = rem;
               rem_nxt     = '0;
               state_nxt   = DONE;
            end
         end
         EJECT: begin
            if (coin_ready) begin
               // Counters saturate, but rem always tracks the coin actually ejected.
               if (coin == COIN_500) begin
                  rem_nxt = rem - VAL_500;
                  if (n500_q != CNT_MAX) n500_nxt = n500_q + CNT_W'(1);
               end else begin
                  rem_nxt = rem - VAL_100;
                  if (n100_q != CNT_MAX) n100_nxt = n100_q + CNT_W'(1);
               end
               state_nxt = CHECK;
            end
         end
         DONE:    state_nxt = IDLE;
         ERROR:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign coin_valid = (state == EJECT);
   assign coin_out   = (state == EJECT) ? coin : COIN_NONE;
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);
   assign error      = (state == ERROR);
   assign n500       = n500_q;
   assign n100       = n100_q;
   assign residuo    = residuo_q;

endmodule
